rsfq_merge_n: RTL and testbench
===============================

RSFQ_MERGE_N -- requirements
Module: rsfq_merge_n

Interface
REQ-001 Parameter N_IN, default 4: number of merged inputs, legal range 2..16.
REQ-002 Parameter DELAY, default 2: input-to-output latency in clk cycles, legal range 1..8.
REQ-003 Parameter CT_WIN, default 3: critical-timing window in cycles after an accepted event, legal range 0..15; 0 disables the window.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 in_tgl  input  N_IN  pulse lines; each toggle of a bit is one SFQ pulse on that input.
REQ-007 clr_err  input  1  one-cycle request that leaves FAULT.
REQ-008 q  output  1  merged pulse line; each toggle is one output pulse.
REQ-009 q_pulse  output  1  one-cycle strobe, high in every cycle in which q toggles.
REQ-010 err  output  1  sticky critical-timing violation flag.
REQ-011 err_src  output  N_IN  edge vector captured in the violating cycle.
REQ-012 evt_cnt  output  16  count of accepted events.

Function
REQ-013 Edge vector: e = in_tgl XOR prev, where prev is the registered in_tgl from the previous cycle.
REQ-014 States: IDLE, WINDOW and FAULT.
REQ-015 IDLE, e==0: the block stays in IDLE.
REQ-016 IDLE, exactly one bit of e set: the event is accepted; the window counter loads CT_WIN and the state becomes WINDOW (it stays IDLE when CT_WIN==0).
REQ-017 Latency: when an event is accepted at rising edge t0, q toggles at rising edge t0+DELAY; q_pulse is high in the cycle following that edge; successive accepted events are never merged or dropped in the delay line.
REQ-018 WINDOW: the counter decrements each cycle; with e==0 at count 1, the state returns to IDLE on the next edge.
REQ-019 WINDOW, e!=0: this is a violation and is handled per REQ-027/REQ-028.
REQ-020 IDLE with two or more bits of e set (simultaneous arrival): this is a violation and is handled per REQ-027/REQ-028.
REQ-021 FAULT: err=1; no new events are accepted; toggles already in the delay line still emerge on q on schedule.
REQ-022 FAULT plus clr_err: next state is IDLE, err=0 and err_src=0; in_tgl edges in that same cycle are ignored.
REQ-023 clr_err outside FAULT has no effect.
REQ-024 evt_cnt increments by 1 per accepted event and wraps from 0xFFFF to 0x0000.

Reset
REQ-025 While rst=1: state=IDLE, q=0, q_pulse=0, err=0, err_src=0, evt_cnt=0, window counter=0, delay line cleared.
REQ-026 Reset behaviour:
- While rst=1, prev loads the current in_tgl, so the first cycle after reset sees no spurious edge.
- Reset mid-operation discards in-flight toggles.
- rst has priority over clr_err and over any edges.

Configuration
REQ-027 With MERGE_CT_CHECK_EN defined: each violation moves the block to FAULT and captures e into err_src; the violating pulses are not accepted and evt_cnt is unchanged.
REQ-028 Without MERGE_CT_CHECK_EN:
- FAULT is unreachable, err is tied to 0 and err_src is tied to 0.
- A violation in WINDOW is accepted as one event and reloads the window counter.
- A simultaneous multi-bit e is accepted as one event: one q toggle, evt_cnt +1.

Verification
REQ-029 N_IN=4, DELAY=2: toggle in_tgl[2] at edge 10 -> q 0->1 at edge 12, q_pulse high for one cycle, evt_cnt=1.
REQ-030 CT_WIN=3: in_tgl[0] toggles at edge 10, then in_tgl[1] at edge 14 -> two q toggles, at edges 12 and 16, err=0, evt_cnt=2.
REQ-031 CHECK_EN defined, CT_WIN=3: in_tgl[0] toggles at edge 10, then in_tgl[3] at edge 12 -> err=1, err_src=4'b1000, only one q toggle at edge 12, evt_cnt=1; clr_err at edge 20 -> err=0, state IDLE.
REQ-032 CHECK_EN undefined: in_tgl[0] and in_tgl[1] toggle together at edge 10 -> single q toggle at edge 12, evt_cnt=1, err=0.
REQ-033 evt_cnt preset to 0xFFFF by 65535 accepted events, then one more event -> evt_cnt=0x0000.
REQ-034 in_tgl[1] toggles at edge 10, rst=1 at edge 11 -> q stays 0 and no q_pulse; after rst falls, with in_tgl held at 4'b0010 -> no event.

Source files
------------

// File: rtl/rsfq_merge_n.sv
// rsfq_merge_n: N-input merger for toggle-encoded SFQ pulse lines.
// Each input toggle is one pulse. Accepted pulses re-emerge as q toggles DELAY cycles later.
// After each accepted event, a CT_WIN-cycle critical-timing window flags closely spaced pulses.
// Build option MERGE_CT_CHECK_EN: when defined, timing violations latch a sticky FAULT state
// (err, err_src), which clr_err clears. When undefined, violating pulses merge into one event
// and err/err_src stay 0.
module rsfq_merge_n #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned DELAY  = 2,
  parameter int unsigned CT_WIN = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] in_tgl,
  input  logic            clr_err,
  output logic            q,
  output logic            q_pulse,
  output logic            err,
  output logic [N_IN-1:0] err_src,
  output logic [15:0]     evt_cnt
);

`ifdef MERGE_CT_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  localparam logic [3:0]      Win = 4'(CT_WIN);
  localparam logic [N_IN-1:0] One = N_IN'(1);

  typedef enum logic [1:0] {StIdle, StWindow, StFault} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [N_IN-1:0] prev_q;
  logic [N_IN-1:0] e;
  logic            multi;
  logic            accept;
  logic            fault_go;
  logic [DELAY-1:0] dl_q;
  logic [DELAY:0]   dl_ext;
  logic            q_q, q_pulse_q;
  logic [15:0]     evt_cnt_q;

  assign e     = in_tgl ^ prev_q;
  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign multi = (e & (e - One)) != '0;

  // Next-state, window counter and accept/violation decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    fault_go = 1'b0;
    case (state_q)
      StIdle: begin
        if (e != '0) begin
          if (multi && CheckEn) begin
            fault_go = 1'b1;
          end else begin
            accept  = 1'b1;
            cnt_d   = Win;
            state_d = (CT_WIN == 0) ? StIdle : StWindow;
          end
        end
      end
      StWindow: begin
        if (e != '0) begin
          if (CheckEn) begin
            fault_go = 1'b1;
          end else begin
            // Violation merged into a single event; window restarts from here.
            accept = 1'b1;
            cnt_d  = Win;
          end
        end else if (cnt_q <= 4'd1) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StFault: begin
        // Edges arriving alongside clr_err are dropped; prev still tracks them.
        if (clr_err) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    if (fault_go) begin
      state_d = StFault;
      cnt_d   = '0;
    end
  end

  // State, window counter and edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      prev_q  <= in_tgl;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= in_tgl;
    end
  end

  // One bit per cycle of latency; each accepted event is its own bit, so none can merge.
  assign dl_ext = {dl_q, accept};

  // Delay line and output toggle flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_q      <= '0;
      q_q       <= 1'b0;
      q_pulse_q <= 1'b0;
    end else begin
      dl_q      <= dl_ext[DELAY-1:0];
      q_q       <= q_q ^ dl_ext[DELAY];
      q_pulse_q <= dl_ext[DELAY];
    end
  end

  // Accepted-event counter, wraps modulo 2^16.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_cnt_q <= '0;
    end else if (accept) begin
      evt_cnt_q <= evt_cnt_q + 16'd1;
    end
  end

  assign q       = q_q;
  assign q_pulse = q_pulse_q;
  assign evt_cnt = evt_cnt_q;

`ifdef MERGE_CT_CHECK_EN
  logic [N_IN-1:0] err_src_q;

  // Capture the offending edge vector on entry to FAULT; clear on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_src_q <= '0;
    end else if (fault_go) begin
      err_src_q <= e;
    end else if ((state_q == StFault) && clr_err) begin
      err_src_q <= '0;
    end
  end

  assign err     = (state_q == StFault);
  assign err_src = err_src_q;
`else
  assign err     = 1'b0;
  assign err_src = '0;
`endif

endmodule

// File: tb/tb_rsfq_merge_n.sv
// Bench for rsfq_merge_n: cycle-level reference model plus directed literal checks.
// Honours MERGE_CT_CHECK_EN the same way the design does.
module tb_rsfq_merge_n;

  localparam int unsigned N   = 4;
  localparam int unsigned DLY = 2;
  localparam int unsigned WIN = 3;

`ifdef MERGE_CT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, clr_err;
  logic [N-1:0] in_tgl;
  logic         q, q_pulse, err;
  logic [N-1:0] err_src;
  logic [15:0]  evt_cnt;

  logic         rst_w, clr_w;
  logic [1:0]   in_w;
  logic         q_w, qp_w, err_w;
  logic [1:0]   err_src_w;
  logic [15:0]  evt_w;

  rsfq_merge_n #(.N_IN(N), .DELAY(DLY), .CT_WIN(WIN)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .in_tgl  (in_tgl),
    .clr_err (clr_err),
    .q       (q),
    .q_pulse (q_pulse),
    .err     (err),
    .err_src (err_src),
    .evt_cnt (evt_cnt)
  );

  // Second instance with no window and one-cycle latency, used for the counter wrap.
  rsfq_merge_n #(.N_IN(2), .DELAY(1), .CT_WIN(0)) u_wrap (
    .clk     (clk),
    .rst     (rst_w),
    .in_tgl  (in_w),
    .clr_err (clr_w),
    .q       (q_w),
    .q_pulse (qp_w),
    .err     (err_w),
    .err_src (err_src_w),
    .evt_cnt (evt_w)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: window = the WIN cycles after the latest accepted event,
  // output toggles held in a queue of due cycle numbers.
  bit           mvalid = 1'b0;
  logic         s_rst, s_clr;
  logic [N-1:0] s_in, m_prev, m_e, m_src;
  int           m_last;
  bit           m_fault, m_viol;
  logic         m_q, m_qp;
  logic [15:0]  m_cnt;
  int           m_due[$];

  always begin
    @(posedge clk);
    s_rst = rst;
    s_in  = in_tgl;
    s_clr = clr_err;
    cyc++;
    #2;
    if (s_rst) begin
      mvalid  = 1'b1;
      m_prev  = s_in;
      m_last  = -1000;
      m_fault = 1'b0;
      m_src   = '0;
      m_q     = 1'b0;
      m_qp    = 1'b0;
      m_cnt   = '0;
      m_due.delete();
    end else if (mvalid) begin
      m_e    = s_in ^ m_prev;
      m_prev = s_in;
      m_qp   = 1'b0;
      if (m_due.size() > 0 && m_due[0] == cyc) begin
        void'(m_due.pop_front());
        m_q  = ~m_q;
        m_qp = 1'b1;
      end
      if (m_fault) begin
        if (s_clr) begin
          m_fault = 1'b0;
          m_src   = '0;
          m_last  = -1000;
        end
      end else if (m_e != '0) begin
        m_viol = ((cyc - m_last) <= int'(WIN)) || ($countones(m_e) > 1);
        if (m_viol && CHK) begin
          m_fault = 1'b1;
          m_src   = m_e;
        end else begin
          m_cnt = m_cnt + 16'd1;
          m_due.push_back(cyc + int'(DLY));
          m_last = cyc;
        end
      end
    end
    if (mvalid) begin
      chk("q", 32'(q), 32'(m_q));
      chk("q_pulse", 32'(q_pulse), 32'(m_qp));
      chk("err", 32'(err), 32'(m_fault));
      chk("err_src", 32'(err_src), 32'(m_src));
      chk("evt_cnt", 32'(evt_cnt), 32'(m_cnt));
    end
  end

  logic [N-1:0] vec [0:21];

  initial begin
    rst = 1'b1; clr_err = 1'b0; in_tgl = '0;
    rst_w = 1'b1; clr_w = 1'b0; in_w = '0;
    step(3);
    chk("reset_q", 32'(q), 32'd0);
    chk("reset_evt", 32'(evt_cnt), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    rst = 1'b0; rst_w = 1'b0;
    step(2);

    // Single event on input 2: q toggles two edges later, one-cycle strobe.
    in_tgl[2] = ~in_tgl[2];
    step(1);
    chk("t1_evt", 32'(evt_cnt), 32'd1);
    chk("t1_q_early", 32'(q), 32'd0);
    step(1);
    chk("t1_q_a1", 32'(q), 32'd0);
    step(1);
    chk("t1_q", 32'(q), 32'd1);
    chk("t1_qp", 32'(q_pulse), 32'd1);
    step(1);
    chk("t1_qp_off", 32'(q_pulse), 32'd0);
    step(4);

    // Events spaced four edges apart: just outside the window.
    in_tgl[0] = ~in_tgl[0];
    step(3);
    chk("t2_q_first", 32'(q), 32'd0);
    chk("t2_qp_first", 32'(q_pulse), 32'd1);
    step(1);
    in_tgl[1] = ~in_tgl[1];
    step(3);
    chk("t2_q_second", 32'(q), 32'd1);
    chk("t2_evt", 32'(evt_cnt), 32'd3);
    chk("t2_err", 32'(err), 32'd0);
    step(4);

    // Second event two edges after the first: inside the window.
    in_tgl[0] = ~in_tgl[0];
    step(2);
    in_tgl[3] = ~in_tgl[3];
    step(1);
    chk("t3_q", 32'(q), 32'd0);
`ifdef MERGE_CT_CHECK_EN
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_src", 32'(err_src), 32'h8);
    chk("t3_evt", 32'(evt_cnt), 32'd4);
    step(6);
    chk("t3_q_hold", 32'(q), 32'd0);
    chk("t3_err_sticky", 32'(err), 32'd1);
    clr_err = 1'b1;
    in_tgl[2] = ~in_tgl[2];
    step(1);
    clr_err = 1'b0;
    chk("t3_clr_err", 32'(err), 32'd0);
    chk("t3_clr_src", 32'(err_src), 32'd0);
    step(3);
    chk("t3_clr_ignored", 32'(evt_cnt), 32'd4);
    chk("t3_q_end", 32'(q), 32'd0);
`else
    chk("t3_err", 32'(err), 32'd0);
    chk("t3_evt", 32'(evt_cnt), 32'd5);
    step(6);
    chk("t3_q_second", 32'(q), 32'd1);
    clr_err = 1'b1;
    in_tgl[2] = ~in_tgl[2];
    step(1);
    clr_err = 1'b0;
    chk("t3_evt_after", 32'(evt_cnt), 32'd6);
    step(3);
    chk("t3_q_end", 32'(q), 32'd0);
`endif
    step(4);

    // Two inputs toggling on the same edge.
    in_tgl[0] = ~in_tgl[0];
    in_tgl[1] = ~in_tgl[1];
    step(1);
`ifdef MERGE_CT_CHECK_EN
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_src", 32'(err_src), 32'h3);
    chk("t4_evt", 32'(evt_cnt), 32'd4);
    step(2);
    chk("t4_q", 32'(q), 32'd0);
`else
    chk("t4_err", 32'(err), 32'd0);
    chk("t4_evt", 32'(evt_cnt), 32'd7);
    step(2);
    chk("t4_q", 32'(q), 32'd1);
`endif
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    step(4);

    // Window boundary: third edge after an accept is still inside the window.
    in_tgl[1] = ~in_tgl[1];
    step(3);
    in_tgl[2] = ~in_tgl[2];
    step(3);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    step(4);

    // Reset while a toggle is in flight.
    in_tgl[1] = ~in_tgl[1];
    step(1);
    rst = 1'b1;
    step(1);
    chk("t6_q_rst", 32'(q), 32'd0);
    chk("t6_evt_rst", 32'(evt_cnt), 32'd0);
    step(1);
    chk("t6_q_due", 32'(q), 32'd0);
    chk("t6_qp_due", 32'(q_pulse), 32'd0);
    rst = 1'b0;
    step(4);
    chk("t6_no_event", 32'(evt_cnt), 32'd0);
    chk("t6_q_after", 32'(q), 32'd0);

    // Mixed toggle-mask stream, checked only by the model.
    vec = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000,
            4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
            4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 22; i++) begin
      in_tgl = in_tgl ^ vec[i];
      step(1);
    end
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    step(6);

    // Counter wrap on the zero-window instance: one accepted event per edge.
    for (int i = 0; i < 65535; i++) begin
      in_w[0] = ~in_w[0];
      step(1);
    end
    chk("wrap_ffff", 32'(evt_w), 32'h0000ffff);
    in_w[0] = ~in_w[0];
    step(1);
    chk("wrap_zero", 32'(evt_w), 32'd0);
    step(2);
    chk("wrap_q", 32'(q_w), 32'd0);
    chk("wrap_err", 32'(err_w), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
